fixed_point_divider: RTL and testbench
======================================

// Module: fixed_point_divider
// PURPOSE
//  Sequential divider for the sign-magnitude fixed-point format {sign, int[INT_W], frac[FRAC_W]}.
//  The frac field holds 0..FRAC_MAX and represents frac/(FRAC_MAX+1).
//  Sits beside the combinational fixed-point ALU and services its FLOAT_DIV opcode;
//  the motion-planning sequencer waits on done.
//  Result is the quotient truncated toward zero, with saturation and error flags.
// PARAMETERS
//  INT_W     21   integer field width
//  FRAC_W    10   fraction field width
//  FRAC_MAX  999  max fraction value; SCALE = FRAC_MAX+1
//  NUM_W     INT_W+2*FRAC_W (41)   internal dividend width (derived, do not override)
// PORTS
//  clk          in   1             system clock, all logic on rising edge
//  reset        in   1             synchronous, active-high
//  start        in   1             request; accepted only in IDLE
//  data_a       in   1+INT_W+FRAC_W  dividend
//  data_b       in   1+INT_W+FRAC_W  divisor
//  busy         out  1             high from accept edge until done cycle ends
//  done         out  1             one-cycle pulse, result/flags valid
//  result       out  1+INT_W+FRAC_W  quotient, held until next accepted start
//  div_by_zero  out  1             divisor magnitude == 0 (held with result)
//  overflow     out  1             quotient integer part > 2^INT_W-1 (held with result)
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset values: state IDLE, busy=0, done=0, result=0, div_by_zero=0, overflow=0.
//  FSM: IDLE -> PREP -> DIV1 -> DIV2 -> DONE -> IDLE.
//  - IDLE: if start, latch operands, sign = a_sign^b_sign, busy<=1.
//  - PREP (1 cycle): MA = a_int*SCALE + a_frac; MB = b_int*SCALE + b_frac;
//    N = MA*SCALE (NUM_W bits, cannot overflow).
//    If MB == 0, go to DONE with div_by_zero=1.
//  - DIV1 (NUM_W cycles): restoring divide, one quotient bit per cycle: Q = N / MB.
//  - DIV2 (NUM_W cycles): same divider reused: QI = Q / SCALE, QF = Q % SCALE.
//  - DONE (1 cycle): done=1, busy=1. Next edge goes to IDLE, busy=0.
//  Latency: done is high exactly 2*NUM_W+3 cycles after the accept edge (85 at defaults).
//  Divide-by-zero path: done is high 2 cycles after the accept edge.
//  Saturation: if QI >= 2^INT_W or div_by_zero, then
//    result = {sign, all-ones int, FRAC_MAX} and the matching flag is set.
//  Zero quotient: the sign bit is forced to 0 (no negative zero).
//  Fraction inputs > FRAC_MAX are out of contract; no checking.
//  start while busy is ignored and does not queue.
//  start in the same cycle as reset: reset wins.
//  reset mid-operation: aborts, and all outputs return to reset values on that edge.
//  Flags clear on the next accepted start.
// STRUCTURE
//  Shared package fpn_pkg holds:
//    INT_W, FRAC_W, FRAC_MAX, SCALE, total length;
//    the fpn_t packed struct {sign, int, frac};
//    the ALU opcode constants (ADD/SUB/MUL/DIV);
//    the divider state enum.
//  One sub-module, fpn_seq_udiv: parametric unsigned restoring divider.
//    Ports: load, dividend, divisor, step, quotient, remainder.
//    Instantiated once and time-shared for DIV1 and DIV2.
//  Top level holds the FSM, the pre-scaling, the saturation logic and the output registers.
// TESTING (FRAC_MAX=999; values written as int.frac)
//  1. 7.500 / 2.500
//     -> done at +85 cycles, result {0,3,0}, flags 0.
//  2. -1.000 / 3.000
//     -> result {1,0,333}, truncation, flags 0.
//  3. 5.000 / 0.000
//     -> done at +2, div_by_zero=1, result {0,2097151,999}.
//  4. 2097151.999 / 0.001
//     -> overflow=1, result {0,2097151,999}.
//  5. -0.001 / 1000.000
//     -> result {0,0,0}, sign forced 0.
//  6. Protocol check:
//     start asserted at +10 during a busy op is ignored, and the first result is unchanged;
//     reset at +40 gives busy=0, done=0, result=0 on the next edge;
//     a fresh start then completes normally.

Source files
------------

// File: rtl/fpn_pkg.sv
// Shared definitions for the sign-magnitude fixed-point number format and the
// units that operate on it (combinational ALU, sequential divider).
package fpn_pkg;

  localparam int INT_W    = 21;
  localparam int FRAC_W   = 10;
  localparam int FRAC_MAX = 999;
  localparam int SCALE    = FRAC_MAX + 1;
  localparam int FPN_W    = 1 + INT_W + FRAC_W;
  localparam int NUM_W    = INT_W + 2 * FRAC_W;

  typedef struct packed {
    logic              sign;
    logic [INT_W-1:0]  int_part;
    logic [FRAC_W-1:0] frac;
  } fpn_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2,
    ALU_DIV = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_DIV1,
    ST_DIV2,
    ST_DONE
  } div_state_e;

endpackage

// File: rtl/fpn_seq_udiv.sv
// Unsigned restoring divider, one quotient bit per step. Load has priority
// over step; after W steps quotient/remainder hold dividend/divisor.
module fpn_seq_udiv #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  input  logic         step,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] q_r;
  logic [W-1:0] r_r;
  logic [W-1:0] d_r;
  logic [W:0]   r_shift;
  logic [W:0]   r_diff;

  // Partial remainder stays below the divisor, so r_shift - d_r borrows into
  // bit W exactly when the trial subtraction must be undone.
  always_comb begin
    r_shift = {r_r, q_r[W-1]};
    r_diff  = r_shift - {1'b0, d_r};
  end

  // NOTE: pure datapath with no reset; every use is preceded by a load, so
  // the power-up contents never reach an output.
  always_ff @(posedge clk) begin
    if (load) begin
      q_r <= dividend;
      r_r <= '0;
      d_r <= divisor;
    end else if (step) begin
      if (!r_diff[W]) begin
        r_r <= r_diff[W-1:0];
        q_r <= {q_r[W-2:0], 1'b1};
      end else begin
        r_r <= r_shift[W-1:0];
        q_r <= {q_r[W-2:0], 1'b0};
      end
    end
  end

  assign quotient  = q_r;
  assign remainder = r_r;

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential sign-magnitude fixed-point divider: pre-scales both operands to
// integers, runs two time-shared restoring divisions, then saturates.
module fixed_point_divider
  import fpn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [FPN_W-1:0] data_a,
  input  logic [FPN_W-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [FPN_W-1:0] result,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int                CNT_W     = $clog2(NUM_W + 1);
  localparam logic [CNT_W-1:0]  LAST_DIV1 = CNT_W'(NUM_W - 1);
  localparam logic [CNT_W-1:0]  LAST_DIV2 = CNT_W'(NUM_W);
  localparam logic [NUM_W-1:0]  SCALE_N   = NUM_W'(SCALE);

  div_state_e       state, state_next;
  fpn_t             a_q, b_q;
  logic             sign_q;
  logic             dz_pending;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  logic [NUM_W-1:0] ma, mb, n;
  logic             div_load, div_step;
  logic [NUM_W-1:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic             quo_ovf, quo_zero;
  fpn_t             sat_value, quo_value;

  assign accept = (state == ST_IDLE) && start && !busy;
  assign sign_q = a_q.sign ^ b_q.sign;

  // Magnitudes as integers in units of 1/SCALE; n carries one extra SCALE so
  // the integer quotient n/mb is the result in units of 1/SCALE.
  always_comb begin
    ma = NUM_W'(a_q.int_part) * SCALE_N + NUM_W'(a_q.frac);
    mb = NUM_W'(b_q.int_part) * SCALE_N + NUM_W'(b_q.frac);
    n  = ma * SCALE_N;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    div_load     = 1'b0;
    div_step     = 1'b0;
    div_dividend = n;
    div_divisor  = mb;
    case (state)
      ST_PREP: div_load = 1'b1;
      ST_DIV1: div_step = 1'b1;
      ST_DIV2: begin
        // First DIV2 cycle reloads the divider with Q / SCALE.
        if (cnt == '0) begin
          div_load     = 1'b1;
          div_dividend = div_quotient;
          div_divisor  = SCALE_N;
        end else begin
          div_step = 1'b1;
        end
      end
      default: ;
    endcase
  end

  fpn_seq_udiv #(.W(NUM_W)) u_udiv (
    .clk       (clk),
    .load      (div_load),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .step      (div_step),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  always_comb begin
    quo_ovf            = |div_quotient[NUM_W-1:INT_W];
    quo_zero           = (div_quotient == '0) && (div_remainder == '0);
    sat_value.sign     = sign_q;
    sat_value.int_part = '1;
    sat_value.frac     = FRAC_W'(FRAC_MAX);
    quo_value.sign     = sign_q & ~quo_zero;
    quo_value.int_part = div_quotient[INT_W-1:0];
    quo_value.frac     = div_remainder[FRAC_W-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_PREP;
      ST_PREP: state_next = (mb == '0) ? ST_DONE : ST_DIV1;
      ST_DIV1: if (cnt == LAST_DIV1) state_next = ST_DIV2;
      ST_DIV2: if (cnt == LAST_DIV2) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      dz_pending  <= 1'b0;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;
      if (accept) begin
        a_q         <= data_a;
        b_q         <= data_b;
        busy        <= 1'b1;
        div_by_zero <= 1'b0;
        overflow    <= 1'b0;
      end
      case (state)
        ST_PREP: begin
          dz_pending <= (mb == '0);
          cnt        <= '0;
        end
        ST_DIV1: cnt <= (cnt == LAST_DIV1) ? '0 : cnt + CNT_W'(1);
        ST_DIV2: cnt <= cnt + CNT_W'(1);
        ST_DONE: begin
          done <= 1'b1;
          if (dz_pending) begin
            result      <= sat_value;
            div_by_zero <= 1'b1;
          end else if (quo_ovf) begin
            result   <= sat_value;
            overflow <= 1'b1;
          end else begin
            result <= quo_value;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider: hand-computed quotients, latency,
// saturation flags and start/reset protocol.
module tb_fixed_point_divider;
  import fpn_pkg::*;

  localparam int LAT    = 2 * NUM_W + 3;
  localparam int LAT_DZ = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [FPN_W-1:0] data_a, data_b;
  logic             busy, done, div_by_zero, overflow;
  logic [FPN_W-1:0] result;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fixed_point_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .data_a      (data_a),
    .data_b      (data_b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  function automatic fpn_t fpn(input bit s, input int unsigned i, input int unsigned f);
    fpn_t v;
    v.sign     = s;
    v.int_part = INT_W'(i);
    v.frac     = FRAC_W'(f);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and count cycles from the accept edge to done.
  task automatic run_op(input fpn_t a, input fpn_t b, output int lat);
    @(negedge clk);
    data_a = a;
    data_b = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    check("flags_clear_on_accept", {div_by_zero, overflow}, 0);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_done(input string tag, input int lat, input int exp_lat,
                            input fpn_t exp_r, input logic exp_dz, input logic exp_ov);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_div_by_zero"}, div_by_zero, exp_dz);
    check({tag, "_overflow"}, overflow, exp_ov);
    check({tag, "_busy_in_done"}, busy, 1);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {done, busy}, 0);
    check({tag, "_result_held"}, result, exp_r);
  endtask

  initial begin
    int   lat;
    logic seen_done;
    fpn_t sat_pos;
    sat_pos = fpn(0, 2097151, 999);

    reset  = 1'b1;
    start  = 1'b0;
    data_a = '0;
    data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, result, div_by_zero, overflow}, 0);
    reset = 1'b0;

    // 7.500 / 2.500 = 3.000
    run_op(fpn(0, 7, 500), fpn(0, 2, 500), lat);
    check_done("t1_7p5_div_2p5", lat, LAT, fpn(0, 3, 0), 0, 0);

    // -1.000 / 3.000 = -0.333 (truncated)
    run_op(fpn(1, 1, 0), fpn(0, 3, 0), lat);
    check_done("t2_neg_third", lat, LAT, fpn(1, 0, 333), 0, 0);

    // 5.000 / 0.000 -> divide by zero, short path
    run_op(fpn(0, 5, 0), fpn(0, 0, 0), lat);
    check_done("t3_div_zero", lat, LAT_DZ, sat_pos, 1, 0);

    // 5.000 / -0.000 -> divide by zero keeps the product sign
    run_op(fpn(0, 5, 0), fpn(1, 0, 0), lat);
    check_done("t3b_div_neg_zero", lat, LAT_DZ, fpn(1, 2097151, 999), 1, 0);

    // 2097151.999 / 0.001 -> overflow
    run_op(fpn(0, 2097151, 999), fpn(0, 0, 1), lat);
    check_done("t4_overflow", lat, LAT, sat_pos, 0, 1);

    // -0.001 / 1000.000 -> zero quotient, sign forced positive
    run_op(fpn(1, 0, 1), fpn(0, 1000, 0), lat);
    check_done("t5_neg_zero", lat, LAT, fpn(0, 0, 0), 0, 0);

    // 2097151.000 / 1.000 -> largest integer, no overflow
    run_op(fpn(0, 2097151, 0), fpn(0, 1, 0), lat);
    check_done("b1_max_int", lat, LAT, fpn(0, 2097151, 0), 0, 0);

    // -1048576.000 / 0.500 -> 2097152, one past the range
    run_op(fpn(1, 1048576, 0), fpn(0, 0, 500), lat);
    check_done("b2_just_over", lat, LAT, fpn(1, 2097151, 999), 0, 1);

    // start while busy is ignored; new operand values must not leak in
    @(negedge clk);
    data_a = fpn(0, 7, 500);
    data_b = fpn(0, 2, 500);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    data_a = fpn(0, 1, 0);
    data_b = fpn(0, 1, 0);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = (c == 10);
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    check_done("p1_start_ignored", lat, LAT, fpn(0, 3, 0), 0, 0);
    seen_done = 1'b0;
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
      seen_done = seen_done | done | busy;
    end
    check("p1_no_queued_op", seen_done, 0);

    // reset 40 cycles into an operation aborts it and clears the outputs
    @(negedge clk);
    data_a = fpn(1, 1, 0);
    data_b = fpn(0, 3, 0);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("p2_reset_mid_op", {busy, done, result, div_by_zero, overflow}, 0);
    reset = 1'b0;

    // start together with reset: reset wins
    @(negedge clk);
    reset  = 1'b1;
    start  = 1'b1;
    data_a = fpn(0, 7, 500);
    data_b = fpn(0, 2, 500);
    @(posedge clk);
    #1;
    check("p3_reset_beats_start", {busy, done}, 0);
    reset = 1'b0;
    start = 1'b0;

    // fresh request after the abort completes normally
    run_op(fpn(1, 1, 0), fpn(0, 3, 0), lat);
    check_done("p4_after_reset", lat, LAT, fpn(1, 0, 333), 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
